// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame/bus widths and the parity helper.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_BUS_W     = 32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Parity bit a transmitter sends for this data; the receiver XORs it with the received parity bit.
    function automatic logic parity_calc(input logic [UART_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial input plus falling-edge detect on the synchronized line.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd,
    output logic rx_s,
    output logic fall_c
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [1:0] warm_q;

    // warm_q keeps the reset-forced highs from looking like a real 1->0 edge when rxd is held low at reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
            warm_q <= 2'd0;
        end else begin
            meta_q <= rxd;
            sync_q <= meta_q;
            prev_q <= sync_q;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

    assign rx_s   = sync_q;
    assign fall_c = (warm_q == 2'd3) & prev_q & ~sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits LSB first, selectable even/odd parity, one stop bit; byte on a 32-bit bus.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rxd,
    input  logic                  rd,
    output logic [UART_BUS_W-1:0] dout,
    output logic                  rxrdy,
    output logic                  pe,
    output logic                  fe,
    output logic                  oe
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    logic rx_s;
    logic fall_c;

    rx_state_t                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                      perr_q, perr_d;
    logic [UART_DATA_BITS-1:0] dout_q, dout_d;
    logic                      rxrdy_d, pe_d, fe_d, oe_d;
    logic                      tick;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (rxd),
        .rx_s  (rx_s),
        .fall_c(fall_c)
    );

    assign tick = (cnt_q == CNT_LAST);
    assign dout = UART_BUS_W'(dout_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            dout_q  <= '0;
            rxrdy   <= 1'b0;
            pe      <= 1'b0;
            fe      <= 1'b0;
            oe      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            dout_q  <= dout_d;
            rxrdy   <= rxrdy_d;
            pe      <= pe_d;
            fe      <= fe_d;
            oe      <= oe_d;
        end
    end

    // Frame sequencing; a read and a completing frame in the same cycle resolve in favour of the new byte
    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        perr_d  = perr_q;
        dout_d  = dout_q;
        rxrdy_d = rxrdy;
        pe_d    = pe;
        fe_d    = fe;
        oe_d    = oe;

        if (rd && rxrdy) begin
            rxrdy_d = 1'b0;
            pe_d    = 1'b0;
            fe_d    = 1'b0;
            oe_d    = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (fall_c) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    perr_d  = parity_calc(shreg_q, PARITY_ODD) ^ rx_s;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    dout_d  = shreg_q;
                    rxrdy_d = 1'b1;
                    pe_d    = perr_q;
                    fe_d    = ~rx_s;
                    oe_d    = rxrdy & ~rd;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed serial frames in, expected bytes/flags queued and checked on delivery.
module tb_uart_receiver;

    localparam int unsigned CPB = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rxd;
    logic        rd;
    logic [31:0] dout;
    logic        rxrdy, pe, fe, oe;

    typedef struct packed {
        logic [31:0] dout;
        logic        pe;
        logic        fe;
        logic        oe;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    logic        prev_rdy  = 1'b0;
    logic        prev_oe   = 1'b0;
    logic [31:0] prev_dout = 32'h0;

    uart_receiver #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rxd  (rxd),
        .rd   (rd),
        .dout (dout),
        .rxrdy(rxrdy),
        .pe   (pe),
        .fe   (fe),
        .oe   (oe)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_byte(input logic [7:0] b, input logic p, input logic f, input logic o);
        exp_t e;
        e = {24'h0, b, p, f, o};
        exp_q.push_back(e);
    endtask

    // Drives the first n bits of {stop, parity, data, start}, each held CPB clocks
    task automatic send_bits(input logic [7:0] data, input logic par, input logic stop, input int n);
        logic [10:0] fr;
        fr = {stop, par, data, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            rxd = fr[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] data, input logic par, input logic stop);
        send_bits(data, par, stop, 11);
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * CPB) @(posedge clk);
        #1;
    endtask

    task automatic rd_pulse();
        @(posedge clk);
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
    endtask

    // Monitor: a delivery is a rising RxRDY, a rising OE, or a Dout change while RxRDY is held
    always @(negedge clk) begin
        if (rst_n && rxrdy && (!prev_rdy || (oe && !prev_oe) || (dout != prev_dout))) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte actual=%h required=none at %0t", dout, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("dout", dout, mon_e.dout);
                check("flags_pe_fe_oe", 32'({pe, fe, oe}), 32'({mon_e.pe, mon_e.fe, mon_e.oe}));
            end
        end
        prev_rdy  = rxrdy;
        prev_oe   = oe;
        prev_dout = dout;
    end

    initial begin
        rst_n = 1'b0;
        rxd   = 1'b0;
        rd    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", dout, 32'h0);
        check("reset_flags", 32'({rxrdy, pe, fe, oe}), 32'h0);

        // Line held low out of reset: no frame without a real high-to-low edge
        rst_n = 1'b1;
        repeat (12 * CPB) @(posedge clk);
        #1;
        check("low_after_reset_rxrdy", 32'(rxrdy), 32'h0);
        idle_bits(2);

        // 1: basic frame and read
        expect_byte(8'h9D, 1'b0, 1'b0, 1'b0);
        send(8'h9D, 1'b1, 1'b1);
        idle_bits(1);
        rd_pulse();
        check("rd_clears_rxrdy", 32'(rxrdy), 32'h0);
        check("rd_keeps_dout", dout, 32'h0000009D);

        // 2: good parity, then bad parity
        expect_byte(8'h99, 1'b0, 1'b0, 1'b0);
        send(8'h99, 1'b0, 1'b1);
        idle_bits(1);
        rd_pulse();
        expect_byte(8'h99, 1'b1, 1'b0, 1'b0);
        send(8'h99, 1'b1, 1'b1);
        idle_bits(1);
        rd_pulse();
        check("rd_clears_pe", 32'({rxrdy, pe}), 32'h0);

        // 3: framing error, then break (line stays low)
        expect_byte(8'h55, 1'b0, 1'b1, 1'b0);
        send(8'h55, 1'b0, 1'b0);
        rd_pulse();
        check("rd_clears_fe", 32'({rxrdy, fe}), 32'h0);
        repeat (3 * 11 * CPB) @(posedge clk);
        #1;
        check("break_no_rxrdy", 32'(rxrdy), 32'h0);
        idle_bits(2);

        // 4a: overrun
        expect_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        send(8'hA5, 1'b0, 1'b1);
        idle_bits(1);
        expect_byte(8'h3C, 1'b0, 1'b0, 1'b1);
        send(8'h3C, 1'b0, 1'b1);
        idle_bits(1);
        rd_pulse();
        check("rd_clears_oe", 32'({rxrdy, oe}), 32'h0);

        // 4b: read in the completion cycle of the second frame
        expect_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        send(8'hA5, 1'b0, 1'b1);
        idle_bits(1);
        expect_byte(8'h3C, 1'b0, 1'b0, 1'b0);
        fork
            send(8'h3C, 1'b0, 1'b1);
            begin
                @(negedge rxd);
                repeat (170) @(posedge clk);
                #1 rd = 1'b1;
                @(posedge clk);
                #1 rd = 1'b0;
            end
        join
        check("rd_same_cycle_rxrdy_oe", 32'({rxrdy, oe}), 32'h2);
        check("rd_same_cycle_dout", dout, 32'h0000003C);
        idle_bits(1);
        rd_pulse();

        // 5: short glitch rejected, then a valid frame
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (CPB / 2 - 2) @(posedge clk);
        #1;
        idle_bits(3);
        check("glitch_no_rxrdy", 32'(rxrdy), 32'h0);
        expect_byte(8'h81, 1'b0, 1'b0, 1'b0);
        send(8'h81, 1'b0, 1'b1);
        idle_bits(1);

        // 6: reset during data bit 4 (0x81 left unread so the clear is visible)
        send_bits(8'hF0, 1'b0, 1'b1, 5);
        rxd = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midframe_reset_dout", dout, 32'h0);
        check("midframe_reset_flags", 32'({rxrdy, pe, fe, oe}), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_bits(8);
        expect_byte(8'hF0, 1'b0, 1'b0, 1'b0);
        send(8'hF0, 1'b0, 1'b1);
        idle_bits(1);
        rd_pulse();

        idle_bits(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_bytes actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
